led_event_scheduler: RTL and testbench
======================================

# led_event_scheduler

Shares the board's two LEDs between four status requesters in the ticket-seller design: idle, coin-accepted, ticket-issued and fault. Each requester posts a one-cycle request; the block queues it and plays that requester's blink pattern for a fixed time, one pattern at a time, in fixed priority order. It contains its own tick divider from the 12 MHz board clock, replacing free-running LED blinkers at the top level.

## Interface
- TICK_DIV, 1_200_000: clk_in cycles per pattern tick (100 ms at 12 MHz); legal range 2..2^24.
- PLAY_TICKS, 20: ticks per pattern play (2 s); legal range 8..255.
- LED_ON, 1'b0: pin level that lights an LED (board LEDs are active-low).
- clk_in  input  1  board clock, 12 MHz; all logic on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- req  input  4  one-cycle request pulses; bit 0 highest priority (fault), bit 3 lowest (idle).
- cancel  input  1  level; aborts the current play and clears all queued requests.
- busy  output  1  high while a pattern plays.
- grant  output  4  one-hot index of the playing requester; 0 when not playing.
- done  output  4  one-cycle pulse on the bit of a requester whose play ran to completion.
- led1  output  1  LED 1 pin.
- led2  output  1  LED 2 pin.

## Operation
- pending[3:0] register: bit i sets on req[i]. It clears when requester i is granted, or on cancel. If req[i] arrives in the same cycle that bit i is granted, pending[i] stays set, giving one further play. Repeated req[i] while pending[i] is set merge into a single play.
- States:
  - IDLE: if pending is non-zero and cancel is low, grant the lowest set index, clear that pending bit, load grant, reset tick divider and tick counter, and go to PLAY.
  - PLAY: the tick divider counts 0..TICK_DIV-1. tcnt increments on each wrap. When tcnt reaches PLAY_TICKS-1 and the divider wraps, pulse done[grant], clear grant and go to IDLE.
  - cancel in PLAY: go to IDLE next cycle with no done pulse; clear pending; a req in the same cycle is dropped.
- A play is never pre-empted by a higher-priority request. Priority applies only at the IDLE decision.
- LED patterns ("on" means the pin equals LED_ON, "off" means ~LED_ON):
  - Grant 0 (fault): led1 on when tcnt[0]==0; led2 is the opposite of led1. This gives alternating blinking at 5 Hz.
  - Grant 1 (coin): led1 steady on, led2 off.
  - Grant 2 (ticket): led2 steady on, led1 off.
  - Grant 3 (idle): both LEDs on when tcnt[2]==0, off otherwise. This gives a slow blink of 4 ticks on, 4 ticks off.
  - IDLE state: both off.
- Widths: the divider is 24 bits; tcnt is 8 bits. Neither ever exceeds its terminal value.

## Timing
- Reset values: state IDLE, pending 0, busy 0, grant 0, done 0, divider 0, tcnt 0, led1 = led2 = ~LED_ON.
- Request latency:
  - req[i] sampled at edge t sets pending[i] after edge t.
  - The grant is taken at edge t+1; busy, grant and the LED pattern are valid after edge t+1.
  - Request-to-LED latency is therefore 2 cycles.
- Play length is exactly PLAY_TICKS*TICK_DIV cycles with busy high. done is high for the single cycle after the final edge, in which busy is already 0.
- Back-to-back plays: the next grant can occur on the edge after done, leaving exactly one IDLE cycle between plays.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-play forces all reset values immediately and asynchronously. Queued requests are lost.

## Test plan
- Single request (TICK_DIV=4, PLAY_TICKS=8): pulse req[1] at cycle 10 -> busy and grant=0010 from cycle 12 for 32 cycles; led1=LED_ON and led2=~LED_ON throughout; done=0010 for one cycle at cycle 44; then LEDs off.
- Priority: pulse req=1000 and req=0001 in the same cycle -> grant 0001 plays first (led1/led2 alternate every 4 cycles), then one idle cycle, then grant 1000 (both LEDs on 16 cycles, off 16 cycles); done pulses in order 0001, 1000.
- No pre-emption and merging: during a grant-3 play, pulse req[0] three times -> grant 3 completes with done[3]; exactly one grant-0 play follows.
- Re-request on grant edge: pulse req[2] in the same cycle it is granted -> two consecutive grant-2 plays, each followed by done[2].
- Cancel: pulse req[0] and req[2], then assert cancel mid-play of grant 0 -> busy=0 next cycle, no done pulse, pending cleared, grant 2 never plays.
- Reset: drop rst_n_in mid-play -> all outputs go to reset values immediately; after release, no play occurs until a new req.

Source files
------------

// File: rtl/led_event_scheduler_if.sv
// rtl/led_event_scheduler_if.sv - request/status/LED bundle between requesters and the LED scheduler
interface led_event_scheduler_if;
   logic [3:0] req;
   logic       cancel;
   logic       busy;
   logic [3:0] grant;
   logic [3:0] done;
   logic       led1;
   logic       led2;

   modport master (output req, cancel, input busy, grant, done, led1, led2);
   modport slave  (input req, cancel, output busy, grant, done, led1, led2);
endinterface

// File: rtl/led_event_scheduler.sv
// rtl/led_event_scheduler.sv - queues four status requesters and plays one LED blink pattern at a time
module led_event_scheduler #(
   parameter int   TICK_DIV   = 1_200_000,
   parameter int   PLAY_TICKS = 20,
   parameter logic LED_ON     = 1'b0
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   led_event_scheduler_if.slave  bus
);
   localparam logic [23:0] DIV_LAST  = 24'(TICK_DIV - 1);
   localparam logic [7:0]  TCNT_LAST = 8'(PLAY_TICKS - 1);
   localparam logic        LED_OFF   = ~LED_ON;

   typedef enum logic {S_IDLE, S_PLAY} state_t;

   state_t      state;
   logic [3:0]  pending;
   logic [23:0] div_cnt;
   logic [7:0]  tcnt;
   logic [3:0]  pick;

   // Lowest set pending bit is the highest-priority waiting requester.
   always_comb pick = pending & (~pending + 4'd1);

   // LED levels {led1, led2} for a given grant at a given tick count.
   function automatic logic [1:0] pattern(input logic [3:0] g, input logic [7:0] t);
      logic [1:0] p;
      p = {LED_OFF, LED_OFF};
      if (g[0])      p = t[0] ? {LED_OFF, LED_ON} : {LED_ON, LED_OFF};
      else if (g[1]) p = {LED_ON, LED_OFF};
      else if (g[2]) p = {LED_OFF, LED_ON};
      else if (g[3]) p = t[2] ? {LED_OFF, LED_OFF} : {LED_ON, LED_ON};
      return p;
   endfunction

   // Scheduler FSM: request queue, tick divider, play timing and registered LED drive.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= S_IDLE;
         pending   <= 4'd0;
         div_cnt   <= 24'd0;
         tcnt      <= 8'd0;
         bus.busy  <= 1'b0;
         bus.grant <= 4'd0;
         bus.done  <= 4'd0;
         bus.led1  <= LED_OFF;
         bus.led2  <= LED_OFF;
      end else begin
         bus.done <= 4'd0;
         if (bus.cancel)
            pending <= 4'd0;
         else if (state == S_IDLE)
            pending <= (pending & ~pick) | bus.req;
         else
            pending <= pending | bus.req;

         case (state)
            S_IDLE: begin
               if (!bus.cancel && pending != 4'd0) begin
                  state                <= S_PLAY;
                  bus.grant            <= pick;
                  bus.busy             <= 1'b1;
                  div_cnt              <= 24'd0;
                  tcnt                 <= 8'd0;
                  {bus.led1, bus.led2} <= pattern(pick, 8'd0);
               end
            end
            S_PLAY: begin
               if (bus.cancel) begin
                  state                <= S_IDLE;
                  bus.busy             <= 1'b0;
                  bus.grant            <= 4'd0;
                  {bus.led1, bus.led2} <= {LED_OFF, LED_OFF};
               end else if (div_cnt == DIV_LAST) begin
                  div_cnt <= 24'd0;
                  if (tcnt == TCNT_LAST) begin
                     state                <= S_IDLE;
                     bus.done             <= bus.grant;
                     bus.grant            <= 4'd0;
                     bus.busy             <= 1'b0;
                     {bus.led1, bus.led2} <= {LED_OFF, LED_OFF};
                  end else begin
                     tcnt                 <= tcnt + 8'd1;
                     {bus.led1, bus.led2} <= pattern(bus.grant, tcnt + 8'd1);
                  end
               end else begin
                  div_cnt <= div_cnt + 24'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_led_event_scheduler.sv
// tb/tb_led_event_scheduler.sv - self-checking bench for led_event_scheduler with a cycle-level reference model
module tb_led_event_scheduler;
   localparam int   TD  = 4;
   localparam int   PT  = 8;
   localparam logic ON  = 1'b0;
   localparam logic OFF = 1'b1;

   logic clk_in = 1'b0;
   logic rst_n_in = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   led_event_scheduler_if bus();

   led_event_scheduler #(.TICK_DIV(TD), .PLAY_TICKS(PT), .LED_ON(ON)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: which requesters wait, who plays, and how many cycles the play has run.
   bit pend [4] = '{0, 0, 0, 0};
   int cur      = -1;
   int elapsed  = 0;
   int done_idx = -1;

   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < 4; i++) pend[i] = 0;
         cur = -1; elapsed = 0; done_idx = -1;
      end else begin
         done_idx = -1;
         if (cur >= 0) begin
            if (bus.cancel) cur = -1;
            else begin
               elapsed++;
               if (elapsed == PT * TD) begin
                  done_idx = cur;
                  cur = -1;
               end
            end
         end else if (!bus.cancel) begin
            int sel;
            sel = -1;
            for (int i = 0; i < 4; i++) if (pend[i] && sel < 0) sel = i;
            if (sel >= 0) begin
               cur = sel; pend[sel] = 0; elapsed = 0;
            end
         end
         for (int i = 0; i < 4; i++) pend[i] = bus.cancel ? 1'b0 : (pend[i] | bus.req[i]);
      end
   end

   function automatic logic [1:0] model_leds(input int c, input int e);
      int tick;
      logic l;
      tick = e / TD;
      case (c)
         0: begin l = (tick % 2 == 0) ? ON : OFF; return {l, ~l}; end
         1: return {ON, OFF};
         2: return {OFF, ON};
         3: begin l = (tick % 8 < 4) ? ON : OFF; return {l, l}; end
         default: return {OFF, OFF};
      endcase
   endfunction

   // Every cycle: DUT outputs must equal the model's view.
   always @(negedge clk_in) begin
      logic [10:0] exp_v;
      exp_v[10]   = (cur >= 0);
      exp_v[9:6]  = (cur >= 0) ? 4'(1 << cur) : 4'd0;
      exp_v[5:2]  = (done_idx >= 0) ? 4'(1 << done_idx) : 4'd0;
      exp_v[1:0]  = model_leds(cur, elapsed);
      chk("cycle_outputs", {bus.busy, bus.grant, bus.done, bus.led1, bus.led2}, exp_v);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic flush();
      @(negedge clk_in) bus.cancel = 1'b1;
      @(negedge clk_in) bus.cancel = 1'b0;
      step(1);
   endtask

   initial begin
      bus.req = 4'd0;
      bus.cancel = 1'b0;
      #1 rst_n_in = 1'b0;
      #1 chk("reset_state", {bus.busy, bus.grant, bus.done, bus.led1, bus.led2}, {1'b0, 4'd0, 4'd0, OFF, OFF});
      step(3);
      rst_n_in = 1'b1;
      step(2);

      // Single request, coin pattern.
      @(negedge clk_in) bus.req = 4'b0010;
      @(negedge clk_in) bus.req = 4'b0000;
      step(1);
      chk("t1_grant", {bus.busy, bus.grant, bus.led1, bus.led2}, {1'b1, 4'b0010, ON, OFF});
      step(31);
      chk("t1_busy_last", bus.busy, 1);
      step(1);
      chk("t1_done", {bus.busy, bus.done, bus.led1, bus.led2}, {1'b0, 4'b0010, OFF, OFF});
      step(1);
      chk("t1_done_clear", bus.done, 0);
      flush();

      // Priority: fault before idle, one idle cycle between.
      @(negedge clk_in) bus.req = 4'b1001;
      @(negedge clk_in) bus.req = 4'b0000;
      step(1);
      chk("t2_grant0", {bus.grant, bus.led1, bus.led2}, {4'b0001, ON, OFF});
      step(4);
      chk("t2_alt", {bus.led1, bus.led2}, {OFF, ON});
      step(28);
      chk("t2_done0", {bus.busy, bus.done}, {1'b0, 4'b0001});
      step(1);
      chk("t2_grant3", {bus.grant, bus.led1, bus.led2}, {4'b1000, ON, ON});
      step(16);
      chk("t2_slow_off", {bus.busy, bus.led1, bus.led2}, {1'b1, OFF, OFF});
      step(16);
      chk("t2_done3", bus.done, 4'b1000);
      flush();

      // No pre-emption; three fault requests merge into one play.
      @(negedge clk_in) bus.req = 4'b1000;
      @(negedge clk_in) bus.req = 4'b0000;
      step(1);
      chk("t3_grant3", bus.grant, 4'b1000);
      step(3);
      bus.req = 4'b0001; step(1); bus.req = 4'b0000; step(5);
      bus.req = 4'b0001; step(1); bus.req = 4'b0000; step(5);
      bus.req = 4'b0001; step(1); bus.req = 4'b0000;
      step(16);
      chk("t3_done3", {bus.busy, bus.done}, {1'b0, 4'b1000});
      step(1);
      chk("t3_grant0", bus.grant, 4'b0001);
      step(32);
      chk("t3_done0", bus.done, 4'b0001);
      step(3);
      chk("t3_single", {bus.busy, bus.grant}, {1'b0, 4'd0});
      flush();

      // Re-request on the grant edge gives two plays.
      @(negedge clk_in) bus.req = 4'b0100;
      step(2);
      bus.req = 4'b0000;
      chk("t4_grant", {bus.grant, bus.led1, bus.led2}, {4'b0100, OFF, ON});
      step(32);
      chk("t4_done_a", bus.done, 4'b0100);
      step(1);
      chk("t4_regrant", {bus.busy, bus.grant}, {1'b1, 4'b0100});
      step(32);
      chk("t4_done_b", bus.done, 4'b0100);
      step(2);
      chk("t4_idle", bus.busy, 0);
      flush();

      // Cancel mid-play drops the queued ticket request.
      @(negedge clk_in) bus.req = 4'b0101;
      @(negedge clk_in) bus.req = 4'b0000;
      step(1);
      chk("t5_grant0", bus.grant, 4'b0001);
      step(10);
      bus.cancel = 1'b1;
      step(1);
      bus.cancel = 1'b0;
      chk("t5_cancel", {bus.busy, bus.grant, bus.done}, {1'b0, 4'd0, 4'd0});
      step(40);
      chk("t5_no_play", {bus.busy, bus.grant}, {1'b0, 4'd0});

      // Asynchronous reset mid-play.
      @(negedge clk_in) bus.req = 4'b1000;
      @(negedge clk_in) bus.req = 4'b0000;
      step(10);
      #2 rst_n_in = 1'b0;
      #1 chk("t6_async_reset", {bus.busy, bus.grant, bus.done, bus.led1, bus.led2}, {1'b0, 4'd0, 4'd0, OFF, OFF});
      @(negedge clk_in) rst_n_in = 1'b1;
      step(20);
      chk("t6_no_play", bus.busy, 0);

      // Random traffic checked against the model every cycle.
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk_in);
         for (int b = 0; b < 4; b++) bus.req[b] = ($urandom_range(0, 23) == 0);
         bus.cancel = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk_in);
      bus.req = 4'd0;
      bus.cancel = 1'b0;
      step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
